// File: rtl/lcd_hex_writer.sv
// Streams a DDRAM set-address command plus a 16-bit value as uppercase ASCII hex
// (optionally prefixed "0x") to an HD44780 driver over a valid/ready byte handshake.
module lcd_hex_writer #(
  parameter int unsigned LINE   = 0,
  parameter int unsigned COL    = 0,
  parameter int unsigned PREFIX = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        update,
  output logic [7:0]  char_data,
  output logic        char_rs,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMD   = 2'd1;
  localparam logic [1:0] PFX   = 2'd2;
  localparam logic [1:0] DIGIT = 2'd3;

  localparam logic [7:0] CMD_BYTE = 8'h80 | ((LINE != 0) ? 8'h40 : 8'h00) | {4'h0, 4'(COL)};

  logic [1:0]  state;
  logic [1:0]  cnt;
  logic [15:0] val_q;
  logic [15:0] next_q;
  logic        pending;
  logic        xfer;
  logic [3:0]  nib;

  assign char_valid = (state != IDLE);
  assign busy       = (state != IDLE);
  assign char_rs    = (state == PFX) || (state == DIGIT);
  assign xfer       = char_valid && char_ready;
  assign nib        = val_q[{cnt, 2'b00} +: 4];

  always_comb begin
    char_data = 8'h00;
    case (state)
      CMD:     char_data = CMD_BYTE;
      PFX:     char_data = (cnt == 2'd0) ? 8'h30 : 8'h78;
      DIGIT:   char_data = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
      default: char_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      val_q   <= '0;
      next_q  <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (update && state != IDLE) begin
        pending <= 1'b1;
        next_q  <= value;
      end
      case (state)
        IDLE: begin
          if (update) begin
            val_q <= value;
            state <= CMD;
          end
        end
        CMD: begin
          if (xfer) begin
            if (PREFIX != 0) begin
              state <= PFX;
              cnt   <= 2'd0;
            end else begin
              state <= DIGIT;
              cnt   <= 2'd3;
            end
          end
        end
        PFX: begin
          if (xfer) begin
            if (cnt == 2'd1) begin
              state <= DIGIT;
              cnt   <= 2'd3;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        default: begin
          if (xfer) begin
            if (cnt == 2'd0) begin
              done <= 1'b1;
              // An update landing on the final transfer restarts directly with
              // the fresh value, so there is no idle gap before the next CMD.
              if (update) begin
                val_q   <= value;
                pending <= 1'b0;
                state   <= CMD;
              end else if (pending) begin
                val_q   <= next_q;
                pending <= 1'b0;
                state   <= CMD;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Bench for lcd_hex_writer: two parameterisations share stimulus; a byte-queue model
// predicts every output each cycle, and literal byte logs pin the model.
module tb_lcd_hex_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        update = 1'b0;
  logic        char_ready = 1'b1;
  logic [7:0]  cd [2];
  logic        crs [2];
  logic        cv [2];
  logic        bsy [2];
  logic        dn [2];

  always #5 clk = ~clk;

  lcd_hex_writer #(.LINE(0), .COL(0), .PREFIX(1)) dut0 (
    .clk(clk), .rst(rst), .value(value), .update(update),
    .char_data(cd[0]), .char_rs(crs[0]), .char_valid(cv[0]),
    .char_ready(char_ready), .busy(bsy[0]), .done(dn[0]));

  lcd_hex_writer #(.LINE(1), .COL(5), .PREFIX(0)) dut1 (
    .clk(clk), .rst(rst), .value(value), .update(update),
    .char_data(cd[1]), .char_rs(crs[1]), .char_valid(cv[1]),
    .char_ready(char_ready), .busy(bsy[1]), .done(dn[1]));

  int vecs = 0;
  int errs = 0;

  task automatic cmp(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  // Model: each instance holds the byte list of its current sequence.
  logic [8:0]  mseq [2][8];
  int          mlen [2];
  int          mpos [2];
  logic        mpend [2];
  logic [15:0] mnext [2];
  logic        mdone [2];

  task automatic mload(input int i, input logic [15:0] v);
    string hx = "0123456789ABCDEF";
    int k = 0;
    int cmdv = 128 + ((i == 1) ? 64 + 5 : 0);
    mseq[i][k] = {1'b0, 8'(cmdv)}; k++;
    if (i == 0) begin
      mseq[i][k] = {1'b1, 8'h30}; k++;
      mseq[i][k] = {1'b1, 8'h78}; k++;
    end
    for (int d = 3; d >= 0; d--) begin
      mseq[i][k] = {1'b1, hx[int'((v >> (4 * d)) & 16'hF)]}; k++;
    end
    mlen[i] = k;
    mpos[i] = 0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mlen[i] = 0; mpos[i] = 0; mpend[i] = 1'b0; mnext[i] = '0; mdone[i] = 1'b0;
      end else begin
        bit b, x, last;
        b = mpos[i] < mlen[i];
        x = b && char_ready;
        last = x && (mpos[i] == mlen[i] - 1);
        mdone[i] = 1'b0;
        if (update && b) begin mpend[i] = 1'b1; mnext[i] = value; end
        if (x) mpos[i]++;
        if (last) begin
          mdone[i] = 1'b1;
          if (update) begin mload(i, value); mpend[i] = 1'b0; end
          else if (mpend[i]) begin mload(i, mnext[i]); mpend[i] = 1'b0; end
        end else if (!b && update) begin
          mload(i, value);
        end
      end
    end
  end

  bit         chk_en = 1'b0;
  logic [8:0] log0[$], log1[$];
  int         dcnt [2] = '{0, 0};
  logic       pv [2] = '{1'b0, 1'b0};
  logic       pr = 1'b0;
  logic [8:0] pd [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit ev;
        logic [8:0] eb;
        ev = mpos[i] < mlen[i];
        eb = ev ? mseq[i][mpos[i]] : 9'h000;
        cmp("char_valid", i, 16'(cv[i]), 16'(ev));
        cmp("busy", i, 16'(bsy[i]), 16'(ev));
        cmp("done", i, 16'(dn[i]), 16'(mdone[i]));
        cmp("byte", i, 16'({crs[i], cd[i]}), 16'(eb));
        if (pv[i] && !pr) cmp("stall_stable", i, 16'({crs[i], cd[i]}), 16'(pd[i]));
        if (cv[i] && char_ready) begin
          if (i == 0) log0.push_back({crs[i], cd[i]});
          else        log1.push_back({crs[i], cd[i]});
        end
        if (dn[i]) dcnt[i]++;
        pv[i] = cv[i];
        pd[i] = {crs[i], cd[i]};
      end
      pr = char_ready;
    end
  end

  bit stall_mode = 1'b0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (!stall_mode) char_ready = 1'b1;
    else if (stall_left > 0) begin char_ready = 1'b0; stall_left--; end
    else begin char_ready = 1'b1; stall_left = $urandom_range(0, 4); end
  end

  task automatic send(input logic [15:0] v);
    value = v; update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      if (mpos[0] >= mlen[0] && mpos[1] >= mlen[1] && !mpend[0] && !mpend[1]) break;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    if (n >= budget) cmp("idle_timeout", 0, 16'(n), 16'(0));
  endtask

  task automatic chk_log(input string name, input int i, input logic [8:0] expq[$]);
    logic [8:0] got[$];
    got = (i == 0) ? log0 : log1;
    cmp({name, "_len"}, i, 16'(got.size()), 16'(expq.size()));
    for (int k = 0; k < expq.size() && k < got.size(); k++)
      cmp(name, i, 16'(got[k]), 16'(expq[k]));
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_valid", 0, 16'(cv[0]), 16'd0);
    cmp("rst_data", 0, 16'(cd[0]), 16'h00);
    cmp("rst_busy", 1, 16'(bsy[1]), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic sequences with ready tied high.
    log0.delete(); log1.delete(); dcnt = '{0, 0};
    send(16'h1234);
    wait_idle(50);
    chk_log("seq1234", 0, '{9'h080, 9'h130, 9'h178, 9'h131, 9'h132, 9'h133, 9'h134});
    chk_log("seq1234", 1, '{9'h0C5, 9'h131, 9'h132, 9'h133, 9'h134});
    cmp("done_cnt", 0, 16'(dcnt[0]), 16'd1);

    log0.delete(); log1.delete();
    send(16'hABCF);
    wait_idle(50);
    chk_log("seqABCF", 1, '{9'h0C5, 9'h141, 9'h142, 9'h143, 9'h146});

    // Random ready stalls.
    log0.delete(); log1.delete();
    stall_mode = 1'b1;
    send(16'h1234);
    wait_idle(400);
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_log("stall1234", 0, '{9'h080, 9'h130, 9'h178, 9'h131, 9'h132, 9'h133, 9'h134});
    chk_log("stall1234", 1, '{9'h0C5, 9'h131, 9'h132, 9'h133, 9'h134});

    // Updates while busy: latest wins.
    log0.delete(); log1.delete(); dcnt = '{0, 0};
    send(16'h0001);
    @(posedge clk); #1;
    send(16'h00FF);
    send(16'hBEEF);
    wait_idle(100);
    chk_log("pend", 0, '{9'h080, 9'h130, 9'h178, 9'h130, 9'h130, 9'h130, 9'h131,
                         9'h080, 9'h130, 9'h178, 9'h142, 9'h145, 9'h145, 9'h146});
    chk_log("pend", 1, '{9'h0C5, 9'h130, 9'h130, 9'h130, 9'h131,
                         9'h0C5, 9'h142, 9'h145, 9'h145, 9'h146});
    cmp("pend_done_cnt", 0, 16'(dcnt[0]), 16'd2);
    cmp("pend_done_cnt", 1, 16'(dcnt[1]), 16'd2);

    // Reset during the third digit discards the sequence and the pending update.
    dcnt = '{0, 0};
    send(16'h1234);
    send(16'h5555);
    for (int n = 0; n < 20 && mpos[0] != 5; n++) begin @(posedge clk); #1; end
    cmp("third_digit_reached", 0, 16'(mpos[0]), 16'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("mid_rst_valid", 0, 16'(cv[0]), 16'd0);
    cmp("mid_rst_data", 0, 16'(cd[0]), 16'h00);
    repeat (5) @(posedge clk);
    #1;
    cmp("mid_rst_no_done", 0, 16'(dcnt[0]), 16'd0);
    cmp("mid_rst_idle", 0, 16'(bsy[0]), 16'd0);
    log0.delete(); log1.delete();
    send(16'h0042);
    wait_idle(50);
    chk_log("after_rst", 0, '{9'h080, 9'h130, 9'h178, 9'h130, 9'h130, 9'h134, 9'h132});

    // Update coinciding with the final transfer.
    send(16'h1111);
    repeat (6) @(posedge clk);
    #1;
    value = 16'h2222; update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
    @(negedge clk);
    cmp("coinc_done", 0, 16'(dn[0]), 16'd1);
    cmp("coinc_busy", 0, 16'(bsy[0]), 16'd1);
    cmp("coinc_cmd", 0, 16'({crs[0], cd[0]}), 16'h080);
    wait_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
